button_press_decoder: RTL and testbench
=======================================

Name: button_press_decoder

Overview:
- Consumes the synchronized, stable button level produced by the button-input conditioning stage and turns it into single-cycle event pulses: press, short release, long-press, release and optional auto-repeat.
- Sits between the button conditioning logic and the control FSMs, so that no consumer has to do its own edge detection or hold timing.
- All outputs are registered on button_clk.

Parameters:
- CNT_W, 8, width of the hold counter.
- LONG_CYCLES, 50, number of consecutive high samples that constitutes a long press. Legal range: 2 to 2^CNT_W-1.
- REPEAT_CYCLES, 10, number of held samples between auto-repeat pulses while in LONG. Legal range: 1 to 2^CNT_W-1.

Ports:
- button_clk  in  1  sole clock.
- reset  in  1  synchronous reset, active-high.
- stableButton  in  1  stable button level, synchronous to button_clk.
- press_pulse  out  1  one-cycle pulse on press.
- short_pulse  out  1  one-cycle pulse on release before LONG_CYCLES is reached.
- long_pulse  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- release_pulse  out  1  one-cycle pulse on every release.
- repeat_pulse  out  1  one-cycle auto-repeat pulse.
- held  out  1  high while the FSM is in PRESS or LONG.
- hold_count  out  CNT_W  consecutive high samples, saturating.

Behaviour:
- Interface: one clock, button_clk. reset is synchronous, active-high, and has priority over every other event.
- Reset values: all pulse outputs 0, held 0, hold_count 0, FSM in IDLE, repeat counter 0.
- FSM states: IDLE, PRESS, LONG.
- Timing reference: t0 is the first edge at which IDLE samples stableButton=1. Outputs update at that edge (one-cycle registered latency).
- IDLE, btn=1: go to PRESS; press_pulse=1; held=1; hold_count=1.
- PRESS, btn=1: hold_count increments. At the edge where hold_count reaches LONG_CYCLES (edge t0+LONG_CYCLES-1): go to LONG, long_pulse=1, repeat counter cleared.
- PRESS, btn=0: go to IDLE; short_pulse=1; release_pulse=1; hold_count=0; held=0.
- LONG, btn=1: hold_count increments, saturating at 2^CNT_W-1, never wrapping.
- LONG, btn=0: go to IDLE; release_pulse=1 only (short_pulse stays 0); hold_count=0.
- Release on the same edge the count would reach LONG_CYCLES: the release wins (btn=0 was sampled), so short_pulse fires and long_pulse does not.
- Pulse width: every pulse output is high for exactly one cycle and deasserts on the following edge regardless of input.
- Reset mid-press: state is discarded. If the button is still high at the first edge after reset deasserts, it is treated as a new press (press_pulse fires, hold_count=1).
- Legality: parameters outside their legal ranges are illegal; the implementation flags them with an elaboration-time check.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: in LONG, the repeat counter increments on each btn=1 edge. When it reaches REPEAT_CYCLES, repeat_pulse=1 and the counter reloads to 0. First repeat occurs at edge t0+LONG_CYCLES-1+REPEAT_CYCLES, then every REPEAT_CYCLES edges. The counter clears on release and on reset.
- Undefined: the repeat counter is not built and repeat_pulse is tied to 0.

Decomposition:
- Shared package button_pkg holds:
  - the state typedef (IDLE, PRESS, LONG);
  - default constants for CNT_W, LONG_CYCLES and REPEAT_CYCLES.
- One sub-module, sat_counter (parameter W; inputs clr, inc; output count; saturates at all-ones). It is instantiated for hold_count and, when the macro is defined, for the repeat counter.

Test Plan:
Bench parameters: CNT_W=4, LONG_CYCLES=5, REPEAT_CYCLES=3.
- Reset held 3 cycles with btn=1 -> all outputs 0 and hold_count=0 throughout. After reset deasserts, press_pulse=1 for one cycle and hold_count=1.
- Btn high for 2 edges, then low -> press_pulse at edge 1; hold_count 1, 2; short_pulse=1 and release_pulse=1 at the release edge; hold_count=0; long_pulse never asserted.
- Btn high for 5 edges, then low -> long_pulse=1 at edge 5 (hold_count=5); at release, release_pulse=1 and short_pulse=0.
- Btn low at the edge that would be edge 5 (4 highs, then low) -> short_pulse=1 and long_pulse=0.
- Btn high for 11 edges -> with BUTTON_AUTO_REPEAT_EN, repeat_pulse at edges 8 and 11; without it, repeat_pulse stays 0.
- Btn high for 20 edges -> hold_count saturates at 15 and holds there; release returns it to 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default parameters for the button press decoder.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_e;

  localparam int DEF_CNT_W         = 8;
  localparam int DEF_LONG_CYCLES   = 50;
  localparam int DEF_REPEAT_CYCLES = 10;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/button_press_decoder.sv
// Turns a stable button level into registered press/short/long/release/repeat pulses.
// Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_press_decoder
  import button_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic             button_clk,
  input  logic             reset,
  input  logic             stableButton,
  output logic             press_pulse,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             release_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] hold_count
);

  localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > MAX_CNT) begin : g_bad_long
    $error("button_press_decoder: LONG_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > MAX_CNT) begin : g_bad_repeat
    $error("button_press_decoder: REPEAT_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  state_e           state_q, state_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             release_q, release_d;
  logic             held_q;
  logic [CNT_W-1:0] hold_count_q;

  // The hold count is zero whenever the button is low, so IDLE+btn lands on 1.
  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (button_clk),
    .clr   (reset | ~stableButton),
    .inc   (stableButton),
    .count (hold_count_q)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stableButton) begin
          state_d = PRESS;
          press_d = 1'b1;
        end
      end
      PRESS: begin
        if (!stableButton) begin
          state_d   = IDLE;
          short_d   = 1'b1;
          release_d = 1'b1;
        end else if (hold_count_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (!stableButton) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge button_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      short_q   <= short_d;
      long_q    <= long_d;
      release_q <= release_d;
      held_q    <= (state_d != IDLE);
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_count;
  logic             rep_inc, rep_hit, repeat_q;

  // Counter is held at 0 outside LONG, so it starts fresh on the LONG entry edge.
  assign rep_inc = (state_q == LONG) && stableButton;
  assign rep_hit = rep_inc && (rep_count == REP_LAST);

  sat_counter #(.W(CNT_W)) u_rep_cnt (
    .clk   (button_clk),
    .clr   (reset | ~rep_inc | rep_hit),
    .inc   (rep_inc),
    .count (rep_count)
  );

  always_ff @(posedge button_clk) begin
    if (reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= rep_hit;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign press_pulse   = press_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign release_pulse = release_q;
  assign held          = held_q;
  assign hold_count    = hold_count_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with CNT_W=4, LONG_CYCLES=5, REPEAT_CYCLES=3.
module tb_button_press_decoder;

  localparam int CNT_W = 4;
  localparam int LONGC = 5;
  localparam int REPC  = 3;
  localparam int SATV  = 15;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             btn;
  logic             press_pulse, short_pulse, long_pulse, release_pulse, repeat_pulse, held;
  logic [CNT_W-1:0] hold_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_press_decoder #(
    .CNT_W         (CNT_W),
    .LONG_CYCLES   (LONGC),
    .REPEAT_CYCLES (REPC)
  ) dut (
    .button_clk    (clk),
    .reset         (reset),
    .stableButton  (btn),
    .press_pulse   (press_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .hold_count    (hold_count)
  );

  // Packed as {press, short, long, release, repeat, held, hold_count}.
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got p/s/l/r/rp/h/cnt=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] vec(input logic p, s, l, r, rp, h, input int hc);
    logic [3:0] c;
    c = 4'(hc);
    return {p, s, l, r, rp, h, c};
  endfunction

  task automatic step(input logic rst, input logic b, input string tag, input logic [9:0] exp);
    reset = rst;
    btn   = b;
    @(posedge clk);
    #1;
    check(tag, {press_pulse, short_pulse, long_pulse, release_pulse, repeat_pulse, held, hold_count}, exp);
  endtask

  // Hold the button for n edges starting from IDLE; expectations follow the press timeline.
  task automatic hold_run(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      logic rp;
      rp = REP_EN && (k > LONGC) && (((k - (LONGC)) % REPC) == 0);
      step(1'b0, 1'b1, $sformatf("%s_e%0d", tag, k),
           vec(k == 1, 1'b0, k == LONGC, 1'b0, rp, 1'b1, (k > SATV) ? SATV : k));
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $sformatf("rst_%0d", i), vec(0, 0, 0, 0, 0, 0, 0));

    // Press straight out of reset, held 2 edges, then short release.
    step(1'b0, 1'b1, "post_rst_press", vec(1, 0, 0, 0, 0, 1, 1));
    step(1'b0, 1'b1, "short_e2",       vec(0, 0, 0, 0, 0, 1, 2));
    step(1'b0, 1'b0, "short_rel",      vec(0, 1, 0, 1, 0, 0, 0));
    step(1'b0, 1'b0, "short_idle",     vec(0, 0, 0, 0, 0, 0, 0));

    // Exactly LONG_CYCLES highs: long pulse at edge 5, release-only afterwards.
    hold_run("long5", 5);
    step(1'b0, 1'b0, "long5_rel",  vec(0, 0, 0, 1, 0, 0, 0));
    step(1'b0, 1'b0, "long5_idle", vec(0, 0, 0, 0, 0, 0, 0));

    // Release on the edge the count would have reached LONG_CYCLES.
    hold_run("edge4", 4);
    step(1'b0, 1'b0, "edge4_rel",  vec(0, 1, 0, 1, 0, 0, 0));
    step(1'b0, 1'b0, "edge4_idle", vec(0, 0, 0, 0, 0, 0, 0));

    // Auto-repeat window.
    hold_run("rep11", 11);
    step(1'b0, 1'b0, "rep11_rel",  vec(0, 0, 0, 1, 0, 0, 0));
    step(1'b0, 1'b0, "rep11_idle", vec(0, 0, 0, 0, 0, 0, 0));

    // Saturation of the hold counter.
    hold_run("sat20", 20);
    step(1'b0, 1'b0, "sat20_rel",  vec(0, 0, 0, 1, 0, 0, 0));
    step(1'b0, 1'b0, "sat20_idle", vec(0, 0, 0, 0, 0, 0, 0));

    // Reset mid-long-press with the button still high: new press afterwards.
    hold_run("midrst", 6);
    step(1'b1, 1'b1, "midrst_rst",   vec(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, "midrst_press", vec(1, 0, 0, 0, 0, 1, 1));
    step(1'b0, 1'b1, "midrst_e2",    vec(0, 0, 0, 0, 0, 1, 2));
    step(1'b0, 1'b0, "midrst_rel",   vec(0, 1, 0, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
